// File: rtl/int_alu_pipe.sv
// int_alu_pipe: pipelined integer ALU / branch resolver with
// bubble collapsing, sqN-based flush and mispredict counting.
module int_alu_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int SQN_W  = 7,
  parameter int TAG_W  = 7,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  output logic             OUT_ready,
  input  logic [4:0]       IN_opcode,
  input  logic [XLEN-1:0]  IN_srcA,
  input  logic [XLEN-1:0]  IN_srcB,
  input  logic [XLEN-1:0]  IN_imm,
  input  logic [XLEN-1:0]  IN_pc,
  input  logic             IN_compressed,
  input  logic             IN_predTaken,
  input  logic [SQN_W-1:0] IN_sqN,
  input  logic [TAG_W-1:0] IN_tagDst,
  input  logic             IN_invalidate,
  input  logic [SQN_W-1:0] IN_invalidateSqN,
  input  logic             IN_wbStall,
  output logic             OUT_valid,
  output logic [XLEN-1:0]  OUT_result,
  output logic [TAG_W-1:0] OUT_tagDst,
  output logic [SQN_W-1:0] OUT_sqN,
  output logic             OUT_redirect,
  output logic [XLEN-1:0]  OUT_dstPC,
  output logic [CNT_W-1:0] OUT_mispredCnt
);

  localparam int SH_W = $clog2(XLEN);
  localparam int L    = STAGES - 1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_XOR  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8;
  localparam logic [4:0] OP_SLTU = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BNE  = 5'd17;
  localparam logic [4:0] OP_BLT  = 5'd18;
  localparam logic [4:0] OP_BGE  = 5'd19;
  localparam logic [4:0] OP_BLTU = 5'd20;
  localparam logic [4:0] OP_BGEU = 5'd21;
  localparam logic [4:0] OP_JAL  = 5'd24;
  localparam logic [4:0] OP_JALR = 5'd25;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  dst_pc;
    logic [TAG_W-1:0] tag;
    logic [SQN_W-1:0] sqn;
    logic             redirect;
  } pl_t;

  // modular age compare: s is strictly younger than base
  function automatic logic younger(
    input logic [SQN_W-1:0] s,
    input logic [SQN_W-1:0] base
  );
    logic [SQN_W-1:0] d;
    d = s - base;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] link, br_tgt, res, tgt;
  logic            eq, lt, ltu, taken, is_br, mis;
  pl_t             cur;

  always_comb begin
    shamt  = IN_srcB[SH_W-1:0];
    eq     = IN_srcA == IN_srcB;
    lt     = $signed(IN_srcA) < $signed(IN_srcB);
    ltu    = IN_srcA < IN_srcB;
    link   = IN_pc + (IN_compressed ? XLEN'(2) : XLEN'(4));
    br_tgt = IN_pc + {{(XLEN-13){IN_imm[12]}}, IN_imm[12:0]};
    res    = '0;
    tgt    = '0;
    taken  = 1'b0;
    is_br  = 1'b0;
    mis    = 1'b0;
    unique case (IN_opcode)
      OP_ADD:  res = IN_srcA + IN_srcB;
      OP_SUB:  res = IN_srcA - IN_srcB;
      OP_XOR:  res = IN_srcA ^ IN_srcB;
      OP_OR:   res = IN_srcA | IN_srcB;
      OP_AND:  res = IN_srcA & IN_srcB;
      OP_SLL:  res = IN_srcA << shamt;
      OP_SRL:  res = IN_srcA >> shamt;
      OP_SRA:  res = XLEN'($signed(IN_srcA) >>> shamt);
      OP_SLT:  res = XLEN'(lt);
      OP_SLTU: res = XLEN'(ltu);
      OP_BEQ:  begin is_br = 1'b1; taken = eq;   end
      OP_BNE:  begin is_br = 1'b1; taken = !eq;  end
      OP_BLT:  begin is_br = 1'b1; taken = lt;   end
      OP_BGE:  begin is_br = 1'b1; taken = !lt;  end
      OP_BLTU: begin is_br = 1'b1; taken = ltu;  end
      OP_BGEU: begin is_br = 1'b1; taken = !ltu; end
      OP_JAL: begin
        res = link;
        tgt = IN_pc + IN_imm;
      end
      OP_JALR: begin
        res = link;
        tgt = (IN_srcA + IN_imm) & ~XLEN'(1);
        mis = 1'b1;
      end
      default: ;
    endcase
    if (is_br) begin
      tgt = taken ? br_tgt : link;
      mis = taken ^ IN_predTaken;
    end
    cur          = '0;
    cur.result   = res;
    cur.dst_pc   = tgt;
    cur.tag      = IN_tagDst;
    cur.sqn      = IN_sqN;
    cur.redirect = mis;
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] adv, kill, in_v, load;
  pl_t               data_q [STAGES];
  pl_t               data_d [STAGES];
  pl_t               in_d   [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // a stage advances if the stage after it advances or is empty
  always_comb begin
    logic run;
    run = !IN_wbStall;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = run;
      run    = run | ~valid_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      kill[k] = IN_invalidate &&
                younger(data_q[k].sqn, IN_invalidateSqN);
      load[k] = ~valid_q[k] | adv[k];
    end
    in_v[0] = IN_valid & ~(IN_invalidate &&
              younger(IN_sqN, IN_invalidateSqN));
    in_d[0] = cur;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = valid_q[k-1] & ~kill[k-1];
      in_d[k] = data_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k] & ~kill[k];
      data_d[k]  = data_q[k];
      if (load[k]) begin
        valid_d[k] = in_v[k];
        if (in_v[k]) data_d[k] = in_d[k];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (OUT_redirect && !IN_wbStall && !kill[L])
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < STAGES; k++) data_q[k] <= data_d[k];
    end
  end

  assign OUT_ready      = ~valid_q[0] | adv[0];
  assign OUT_valid      = valid_q[L];
  assign OUT_result     = data_q[L].result;
  assign OUT_tagDst     = data_q[L].tag;
  assign OUT_sqN        = data_q[L].sqn;
  assign OUT_redirect   = valid_q[L] & data_q[L].redirect;
  assign OUT_dstPC      = data_q[L].dst_pc;
  assign OUT_mispredCnt = cnt_q;

endmodule

// File: tb/tb_int_alu_pipe.sv
// Directed and randomized bench for int_alu_pipe (STAGES=2),
// random ops checked against an in-order scoreboard model.
module tb_int_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_valid;
  logic        OUT_ready;
  logic [4:0]  IN_opcode;
  logic [31:0] IN_srcA, IN_srcB, IN_imm, IN_pc;
  logic        IN_compressed, IN_predTaken;
  logic [6:0]  IN_sqN, IN_tagDst;
  logic        IN_invalidate;
  logic [6:0]  IN_invalidateSqN;
  logic        IN_wbStall;
  logic        OUT_valid;
  logic [31:0] OUT_result;
  logic [6:0]  OUT_tagDst, OUT_sqN;
  logic        OUT_redirect;
  logic [31:0] OUT_dstPC;
  logic [15:0] OUT_mispredCnt;

  int checks   = 0;
  int failures = 0;

  int_alu_pipe #(
    .XLEN(32), .STAGES(2), .SQN_W(7), .TAG_W(7), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .IN_valid(IN_valid), .OUT_ready(OUT_ready),
    .IN_opcode(IN_opcode),
    .IN_srcA(IN_srcA), .IN_srcB(IN_srcB),
    .IN_imm(IN_imm), .IN_pc(IN_pc),
    .IN_compressed(IN_compressed),
    .IN_predTaken(IN_predTaken),
    .IN_sqN(IN_sqN), .IN_tagDst(IN_tagDst),
    .IN_invalidate(IN_invalidate),
    .IN_invalidateSqN(IN_invalidateSqN),
    .IN_wbStall(IN_wbStall),
    .OUT_valid(OUT_valid), .OUT_result(OUT_result),
    .OUT_tagDst(OUT_tagDst), .OUT_sqN(OUT_sqN),
    .OUT_redirect(OUT_redirect), .OUT_dstPC(OUT_dstPC),
    .OUT_mispredCnt(OUT_mispredCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [6:0]  tag;
    logic [6:0]  sqn;
    logic        redir;
    bit          chk_res;
    bit          chk_pc;
  } exp_t;

  exp_t q[$];

  task automatic chk(string t, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] op,
                     input logic [31:0] a, b, imm, pc,
                     input logic c, pt,
                     input logic [6:0] sq, tg);
    IN_valid      = 1'b1;
    IN_opcode     = op;
    IN_srcA       = a;
    IN_srcB       = b;
    IN_imm        = imm;
    IN_pc         = pc;
    IN_compressed = c;
    IN_predTaken  = pt;
    IN_sqN        = sq;
    IN_tagDst     = tg;
  endtask

  task automatic idle;
    IN_valid = 1'b0;
  endtask

  function automatic bit is_younger(logic [6:0] s, logic [6:0] b);
    int d;
    d = (int'(s) - int'(b) + 128) % 128;
    return d > 0 && d < 64;
  endfunction

  // reference behaviour of one op, from the ISA rules
  function automatic exp_t model(logic [4:0] op,
                                 logic [31:0] a, b, imm, pc,
                                 logic c, pt,
                                 logic [6:0] sq, tg);
    exp_t e;
    longint sa, sb;
    bit take;
    logic [31:0] step;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    step = c ? 32'd2 : 32'd4;
    e = '{res: 0, pc: 0, tag: tg, sqn: sq, redir: 0,
          chk_res: 1, chk_pc: 0};
    take = 0;
    case (op)
      0: e.res = a + b;
      1: e.res = a - b;
      2: e.res = a ^ b;
      3: e.res = a | b;
      4: e.res = a & b;
      5: e.res = a << (b % 32);
      6: e.res = a >> (b % 32);
      7: e.res = 32'(sa >>> (b % 32));
      8: e.res = (sa < sb) ? 1 : 0;
      9: e.res = (a < b) ? 1 : 0;
      16, 17, 18, 19, 20, 21: begin
        case (op)
          16: take = a == b;
          17: take = a != b;
          18: take = sa < sb;
          19: take = sa >= sb;
          20: take = a < b;
          default: take = a >= b;
        endcase
        e.chk_res = 0;
        e.chk_pc  = 1;
        e.pc = take ? pc + 32'($signed(imm[12:0])) : pc + step;
        e.redir = take != pt;
      end
      24: begin
        e.res = pc + step;
        e.pc = pc + imm;
        e.chk_pc = 1;
      end
      25: begin
        e.res = pc + step;
        e.pc = (a + imm) & 32'hFFFF_FFFE;
        e.chk_pc = 1;
        e.redir = 1;
      end
      default: e.res = 0;
    endcase
    return e;
  endfunction

  int          ops[20] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9,
                           16, 17, 18, 19, 20, 21, 24, 25, 11, 31};
  logic [15:0] mcnt;
  logic [6:0]  sqc;
  logic [6:0]  isq;
  logic        v, st, inv;
  logic [4:0]  op;
  logic [31:0] ra, rb, ri, rp;
  logic        rc, rpt;
  exp_t        e;
  exp_t        keep[$];

  task automatic score(string t);
    exp_t x;
    chk({t, "_cnt"}, OUT_mispredCnt, mcnt);
    chk({t, "_redir_needs_valid"},
        OUT_redirect & ~OUT_valid, 0);
    if (OUT_valid && !IN_wbStall) begin
      if (q.size() == 0) begin
        chk({t, "_spurious_out"}, OUT_sqN, 7'h7f ^ OUT_sqN);
      end else begin
        x = q.pop_front();
        chk({t, "_sqn"}, OUT_sqN, x.sqn);
        chk({t, "_tag"}, OUT_tagDst, x.tag);
        chk({t, "_redirect"}, OUT_redirect, x.redir);
        if (x.chk_res) chk({t, "_result"}, OUT_result, x.res);
        if (x.chk_pc) chk({t, "_dstpc"}, OUT_dstPC, x.pc);
        if (x.redir) mcnt = mcnt + 16'd1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    IN_valid = 0; IN_opcode = 0; IN_srcA = 0; IN_srcB = 0;
    IN_imm = 0; IN_pc = 0; IN_compressed = 0;
    IN_predTaken = 0; IN_sqN = 0; IN_tagDst = 0;
    IN_invalidate = 0; IN_invalidateSqN = 0; IN_wbStall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", OUT_valid, 0);
    chk("rst_redirect", OUT_redirect, 0);
    chk("rst_cnt", OUT_mispredCnt, 0);
    chk("rst_result", OUT_result, 0);
    chk("rst_dstpc", OUT_dstPC, 0);
    chk("rst_ready", OUT_ready, 1);
    tick;
    rst = 1'b0;

    // back-to-back ADD / SUB
    put(0, 3, 4, 0, 0, 0, 0, 1, 5);
    @(negedge clk); chk("add_ready", OUT_ready, 1); tick;
    put(1, 3, 4, 0, 0, 0, 0, 2, 6);
    @(negedge clk); chk("sub_ready", OUT_ready, 1);
    chk("lat_not_early", OUT_valid, 0); tick;
    idle;
    @(negedge clk);
    chk("add_valid", OUT_valid, 1);
    chk("add_result", OUT_result, 7);
    chk("add_sqn", OUT_sqN, 1);
    chk("add_tag", OUT_tagDst, 5);
    tick;
    @(negedge clk);
    chk("sub_valid", OUT_valid, 1);
    chk("sub_result", OUT_result, 32'hFFFF_FFFF);
    chk("sub_sqn", OUT_sqN, 2);
    tick;
    @(negedge clk); chk("drained", OUT_valid, 0);

    // BEQ mispredicted, then correctly predicted
    put(16, 5, 5, 32'h20, 32'h100, 0, 0, 3, 1); tick;
    idle; tick;
    @(negedge clk);
    chk("beq_redirect", OUT_redirect, 1);
    chk("beq_dstpc", OUT_dstPC, 32'h120);
    chk("beq_cnt_before", OUT_mispredCnt, 0);
    tick;
    @(negedge clk); chk("beq_cnt_after", OUT_mispredCnt, 1);
    put(16, 5, 5, 32'h20, 32'h100, 0, 1, 4, 1); tick;
    idle; tick;
    @(negedge clk);
    chk("beq_ok_valid", OUT_valid, 1);
    chk("beq_ok_redirect", OUT_redirect, 0);
    tick;
    @(negedge clk); chk("beq_ok_cnt", OUT_mispredCnt, 1);

    // writeback stall for 3 cycles
    put(0, 1, 1, 0, 0, 0, 0, 20, 1); tick;
    idle; tick;
    put(0, 2, 2, 0, 0, 0, 0, 21, 2); IN_wbStall = 1;
    @(negedge clk);
    chk("st_bubble_ready", OUT_ready, 1);
    chk("st0_sqn", OUT_sqN, 20);
    tick;
    put(0, 3, 3, 0, 0, 0, 0, 22, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("st_full_ready", OUT_ready, 0);
      chk("st_hold_valid", OUT_valid, 1);
      chk("st_hold_sqn", OUT_sqN, 20);
      chk("st_hold_result", OUT_result, 2);
      tick;
    end
    IN_wbStall = 0;
    @(negedge clk);
    chk("st_rel_ready", OUT_ready, 1);
    chk("st_rel_sqn", OUT_sqN, 20);
    tick;
    idle;
    @(negedge clk);
    chk("st_b_sqn", OUT_sqN, 21);
    chk("st_b_result", OUT_result, 4);
    tick;
    @(negedge clk);
    chk("st_c_sqn", OUT_sqN, 22);
    chk("st_c_result", OUT_result, 6);
    tick;
    @(negedge clk); chk("st_empty", OUT_valid, 0);

    // invalidation, plain and across sqN wrap
    put(0, 1, 0, 0, 0, 0, 0, 10, 1); tick;
    put(0, 1, 0, 0, 0, 0, 0, 11, 1); tick;
    put(0, 1, 0, 0, 0, 0, 0, 12, 1);
    IN_invalidate = 1; IN_invalidateSqN = 10;
    @(negedge clk);
    chk("inv_out_valid", OUT_valid, 1);
    chk("inv_out_sqn", OUT_sqN, 10);
    tick;
    idle; IN_invalidate = 0;
    @(negedge clk); chk("inv_kill1", OUT_valid, 0); tick;
    @(negedge clk); chk("inv_kill2", OUT_valid, 0);
    put(0, 1, 0, 0, 0, 0, 0, 126, 1); tick;
    put(0, 1, 0, 0, 0, 0, 0, 127, 1); tick;
    put(0, 1, 0, 0, 0, 0, 0, 0, 1);
    IN_invalidate = 1; IN_invalidateSqN = 127;
    @(negedge clk); chk("wrap_126", OUT_sqN, 126); tick;
    idle; IN_invalidate = 0;
    @(negedge clk);
    chk("wrap_127_valid", OUT_valid, 1);
    chk("wrap_127_sqn", OUT_sqN, 127);
    tick;
    @(negedge clk); chk("wrap_0_killed", OUT_valid, 0);

    // compressed JALR
    put(25, 32'h1001, 0, 0, 32'h200, 1, 0, 30, 9); tick;
    idle; tick;
    @(negedge clk);
    chk("jalr_result", OUT_result, 32'h202);
    chk("jalr_dstpc", OUT_dstPC, 32'h1000);
    chk("jalr_redirect", OUT_redirect, 1);
    tick;
    @(negedge clk); chk("jalr_cnt", OUT_mispredCnt, 2);
    tick;

    // randomized traffic against the scoreboard
    mcnt = 2;
    sqc  = 40;
    for (int i = 0; i < 600; i++) begin
      v   = $urandom_range(0, 9) < 7;
      op  = 5'(ops[$urandom_range(0, 19)]);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 40);
      ri  = $urandom;
      rp  = $urandom;
      rc  = 1'($urandom_range(0, 1));
      rpt = 1'($urandom_range(0, 1));
      st  = $urandom_range(0, 3) == 0;
      inv = $urandom_range(0, 19) == 0;
      if (inv) st = 1;
      isq = sqc - 7'($urandom_range(0, 4));
      if (v) put(op, ra, rb, ri, rp, rc, rpt, sqc,
                 7'($urandom));
      else idle;
      IN_wbStall = st;
      IN_invalidate = inv;
      IN_invalidateSqN = isq;
      @(negedge clk);
      score("rnd");
      if (inv) begin
        keep = {};
        foreach (q[j])
          if (!is_younger(q[j].sqn, isq)) keep.push_back(q[j]);
        q = keep;
      end
      if (v && OUT_ready && !(inv && is_younger(sqc, isq))) begin
        e = model(op, ra, rb, ri, rp, rc, rpt, sqc, IN_tagDst);
        q.push_back(e);
      end
      if (v) sqc = sqc + 7'd1;
      tick;
    end
    idle; IN_wbStall = 0; IN_invalidate = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      score("drain");
      tick;
    end
    chk("drain_queue_empty", q.size(), 0);
    chk("drain_out_idle", OUT_valid, 0);

    // async reset mid-stream with two valid stages
    rst = 1; #2; rst = 0;
    mcnt = 0;
    for (int i = 0; i < 5; i++) begin
      put(25, 32'h400, 0, 0, 0, 0, 0, 7'(60 + i), 1);
      tick;
    end
    put(0, 1, 1, 0, 0, 0, 0, 70, 1); tick;
    put(0, 1, 1, 0, 0, 0, 0, 71, 1); tick;
    idle;
    @(negedge clk);
    chk("pre_rst_cnt", OUT_mispredCnt, 5);
    chk("pre_rst_valid", OUT_valid, 1);
    #1 rst = 1;
    #1;
    chk("arst_valid", OUT_valid, 0);
    chk("arst_cnt", OUT_mispredCnt, 0);
    chk("arst_redirect", OUT_redirect, 0);
    chk("arst_ready", OUT_ready, 1);
    chk("arst_result", OUT_result, 0);
    #1 rst = 0;
    tick;
    put(0, 9, 1, 0, 0, 0, 0, 50, 3);
    @(negedge clk); tick;
    idle;
    @(negedge clk); chk("post_rst_early", OUT_valid, 0); tick;
    @(negedge clk);
    chk("post_rst_valid", OUT_valid, 1);
    chk("post_rst_result", OUT_result, 10);
    chk("post_rst_sqn", OUT_sqN, 50);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
